mem_bist_master: RTL and testbench
==================================

Name: mem_bist_master

Overview:
- Self-test initiator for the half-swapping register-file memory (write port + registered read port).
- Drives the memory's in_wr/in_rd/address/data inputs:
  - writes a deterministic pattern to every address;
  - reads every address back;
  - compares each read against the expected stored image, including the upper-half 16/16 swap.
- Reports pass/fail, first failing address and error count to the test controller.

Parameters:
- WIDTH, 32, data word width; must be even.
- PSIZE, 4, address width.
- DEPTH, 2**PSIZE, number of words.
- SEED, 32'hA5C3_0F96, pattern base, truncated to WIDTH.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- start  in  1  begin a test run; sampled in IDLE or DONE only.
- out_wr  out  1  memory write enable.
- out_rd  out  1  memory read enable.
- out_data  out  WIDTH  memory write data.
- out_wr_addr  out  PSIZE  memory write address.
- out_rd_addr  out  PSIZE  memory read address.
- rd_data  in  WIDTH  memory registered read data, valid one cycle after out_rd.
- busy  out  1  high in WRITE, READ, DRAIN.
- done  out  1  high in DONE.
- pass  out  1  done && err_count==0.
- fail_addr  out  PSIZE  address of first mismatch.
- err_count  out  PSIZE+1  number of mismatches, max DEPTH.

Behaviour:
- Reset (async, immediate): state IDLE. All outputs 0: out_wr, out_rd, out_data, both addrs, busy, done, pass, fail_addr, err_count. Compare pipeline cleared.
- All memory-side outputs are registered.
- out_wr and out_rd are never high in the same cycle. This is a hard requirement of the memory.
- Pattern: P(a) = SEED ^ zero_extend(a).
- Expected stored image:
  - E(a) = P(a) for a < DEPTH/2;
  - E(a) = {P(a)[WIDTH/2-1:0], P(a)[WIDTH-1:WIDTH/2]} for a >= DEPTH/2.
- IDLE: start=1 at edge 0 -> WRITE, address counter 0, err_count 0, fail_addr 0.
- WRITE: for DEPTH cycles, out_wr=1, out_wr_addr=a, out_data=P(a), a = 0..DEPTH-1. After the last write -> READ, counter 0.
- READ: for DEPTH cycles, out_rd=1, out_rd_addr=a, out_wr=0.
  - Each read pushes (valid, a) into a one-stage compare pipe.
  - In the next cycle, rd_data is compared with E(a).
  - After the last read -> DRAIN.
- DRAIN: one cycle, no memory access; the last address is compared -> DONE.
- Mismatch handling: err_count increments, saturating at DEPTH. fail_addr is captured only on the first mismatch of a run.
- DONE: done=1; results held stable. start=1 restarts the run (same as IDLE, counters cleared).
- start is ignored while busy.
- Latency: done rises after edge 2*DEPTH+1 relative to edge 0 (33 for defaults). busy is high for exactly 2*DEPTH+1 cycles.
- Address counter wraps from DEPTH-1 only at phase transitions; no out-of-range address is ever driven.
- Reset asserted mid-run: run abandoned, outputs zero asynchronously. After release, IDLE waits for start; no partial results survive.

Test Plan:
- Clean run: defaults, bench memory model (swap on addr >= 8), start pulse at edge 0.
  - Required: 16 writes, addr 0 data A5C30F96; addr 9 data A5C30F9F (stored 0F9FA5C3).
  - Then 16 reads.
  - done=1 after edge 33, pass=1, err_count=0, out_wr&out_rd never both 1.
- Single fault: memory model flips bit 0 of addr 9 on read.
  - Required: err_count=1, fail_addr=9, pass=0.
- Non-swapping memory (plain RAM) substituted.
  - Required: err_count=8, fail_addr=8, pass=0.
- Stuck-at-zero read data (rd_data=0 always).
  - Required: err_count=16 (no overflow), fail_addr=0, pass=0.
- Reset mid-READ at edge 20, released at edge 22, then start again.
  - Required: all outputs 0 immediately on rst, IDLE until start, then clean run passes.
- Control corner cases.
  - start held high throughout a run: no restart until DONE.
  - start in DONE: counters cleared, new run passes.

Source files
------------

// File: rtl/mem_bist_master.sv
// Self-test initiator for the half-swapping register-file memory.
// Writes a seeded pattern to every word, reads each word back, and compares it
// against the expected stored image (upper half of the address space swapped
// 16/16). Reports pass/fail, the first failing address and a saturating error count.
module mem_bist_master #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned PSIZE = 4,
  parameter int unsigned DEPTH = 2 ** PSIZE,
  parameter logic [31:0] SEED  = 32'hA5C3_0F96
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             out_wr,
  output logic             out_rd,
  output logic [WIDTH-1:0] out_data,
  output logic [PSIZE-1:0] out_wr_addr,
  output logic [PSIZE-1:0] out_rd_addr,
  input  logic [WIDTH-1:0] rd_data,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [PSIZE-1:0] fail_addr,
  output logic [PSIZE:0]   err_count
);

  localparam int unsigned    HALF      = WIDTH / 2;
  localparam logic [PSIZE-1:0] LAST_ADDR = PSIZE'(DEPTH - 1);
  localparam logic [PSIZE-1:0] SWAP_ADDR = PSIZE'(DEPTH / 2);
  localparam logic [PSIZE:0]   MAX_ERR   = (PSIZE + 1)'(DEPTH);
  localparam logic [WIDTH-1:0] BASE      = WIDTH'(SEED);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WRITE = 3'd1,
    READ  = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t           state;
  logic [PSIZE-1:0] addr;
  logic             pipe_valid;
  logic [PSIZE-1:0] pipe_addr;
  logic             mismatch;
  logic [PSIZE:0]   err_next;

  // Write pattern for an address.
  function automatic logic [WIDTH-1:0] pattern(input logic [PSIZE-1:0] a);
    return BASE ^ WIDTH'(a);
  endfunction

  // Image the memory is expected to hold: upper-half addresses are half-swapped.
  function automatic logic [WIDTH-1:0] image(input logic [PSIZE-1:0] a);
    logic [WIDTH-1:0] p;
    p = pattern(a);
    if (a >= SWAP_ADDR) return {p[HALF-1:0], p[WIDTH-1:HALF]};
    return p;
  endfunction

  // Compare the read data returned for the address issued last cycle.
  always_comb begin
    mismatch = pipe_valid && (rd_data != image(pipe_addr));
    err_next = err_count;
    if (mismatch && (err_count != MAX_ERR)) err_next = err_count + (PSIZE + 1)'(1);
  end

  // Sequencer, compare pipe and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      addr        <= '0;
      pipe_valid  <= 1'b0;
      pipe_addr   <= '0;
      out_wr      <= 1'b0;
      out_rd      <= 1'b0;
      out_data    <= '0;
      out_wr_addr <= '0;
      out_rd_addr <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      pass        <= 1'b0;
      fail_addr   <= '0;
      err_count   <= '0;
    end else begin
      pipe_valid <= out_rd;
      pipe_addr  <= out_rd_addr;
      if (mismatch) begin
        err_count <= err_next;
        if (err_count == '0) fail_addr <= pipe_addr;
      end
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state       <= WRITE;
            addr        <= '0;
            out_wr      <= 1'b1;
            out_rd      <= 1'b0;
            out_wr_addr <= '0;
            out_data    <= pattern('0);
            busy        <= 1'b1;
            done        <= 1'b0;
            pass        <= 1'b0;
            err_count   <= '0;
            fail_addr   <= '0;
          end
        end
        WRITE: begin
          if (addr == LAST_ADDR) begin
            state       <= READ;
            addr        <= '0;
            out_wr      <= 1'b0;
            out_rd      <= 1'b1;
            out_rd_addr <= '0;
          end else begin
            addr        <= addr + PSIZE'(1);
            out_wr_addr <= addr + PSIZE'(1);
            out_data    <= pattern(addr + PSIZE'(1));
          end
        end
        READ: begin
          if (addr == LAST_ADDR) begin
            state  <= DRAIN;
            addr   <= '0;
            out_rd <= 1'b0;
          end else begin
            addr        <= addr + PSIZE'(1);
            out_rd_addr <= addr + PSIZE'(1);
          end
        end
        DRAIN: begin
          state <= DONE;
          busy  <= 1'b0;
          done  <= 1'b1;
          pass  <= (err_next == '0);
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bist_master.sv
// Bench for mem_bist_master: behavioural half-swapping memory with fault hooks,
// directed runs plus randomized fault maps checked against an address-level model.
module tb_mem_bist_master;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        out_wr, out_rd, busy, done, pass;
  logic [31:0] out_data, rd_data;
  logic [3:0]  out_wr_addr, out_rd_addr, fail_addr;
  logic [4:0]  err_count;

  int checks = 0;
  int errors = 0;

  // Memory model controls
  bit          swap_en = 1'b1;
  bit          stuck = 1'b0;
  logic [31:0] flt [16];
  logic [31:0] mem [16];
  logic [31:0] rd_q;

  // Run observations
  logic [31:0] wr_data [16];
  int wr_cnt, rd_cnt, overlap, busy_cnt, done_k;

  mem_bist_master dut (
    .clk(clk), .rst(rst), .start(start),
    .out_wr(out_wr), .out_rd(out_rd), .out_data(out_data),
    .out_wr_addr(out_wr_addr), .out_rd_addr(out_rd_addr), .rd_data(rd_data),
    .busy(busy), .done(done), .pass(pass), .fail_addr(fail_addr), .err_count(err_count)
  );

  always #5 clk = ~clk;

  // Register file: stores upper-half words swapped, registered read with fault mask
  always @(posedge clk) begin
    if (out_wr) mem[out_wr_addr] <= (swap_en && out_wr_addr[3]) ? {out_data[15:0], out_data[31:16]} : out_data;
    if (out_rd) rd_q <= mem[out_rd_addr] ^ flt[out_rd_addr];
  end
  assign rd_data = stuck ? 32'h0 : rd_q;

  function automatic logic [31:0] pat(input int a);
    return 32'hA5C3_0F96 ^ 32'(a);
  endfunction

  function automatic logic [31:0] hswap(input logic [31:0] v);
    return {v[15:0], v[31:16]};
  endfunction

  // What the BIST should expect at address a
  function automatic logic [31:0] want(input int a);
    return (a >= 8) ? hswap(pat(a)) : pat(a);
  endfunction

  // What the modelled memory actually returns at address a
  function automatic logic [31:0] got(input int a);
    if (stuck) return 32'h0;
    return ((swap_en && a >= 8) ? hswap(pat(a)) : pat(a)) ^ flt[a];
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_faults();
    for (int a = 0; a < 16; a++) flt[a] = 32'h0;
  endtask

  // One run: start pulse (or held start), follow until done, check results
  task automatic run(input string name, input bit hold, input bit use_model,
                     input int exp_err_in, input int exp_fail_in);
    int exp_err, exp_fail;
    logic [4:0] ec;
    exp_err  = exp_err_in;
    exp_fail = exp_fail_in;
    if (use_model) begin
      exp_err = 0; exp_fail = 0;
      for (int a = 0; a < 16; a++)
        if (got(a) !== want(a)) begin
          if (exp_err == 0) exp_fail = a;
          exp_err++;
        end
      if (exp_err > 16) exp_err = 16;
    end
    wr_cnt = 0; rd_cnt = 0; overlap = 0; busy_cnt = 0; done_k = -1;
    @(negedge clk);
    start = 1'b1;
    for (int k = 0; k < 80; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (!hold) start = 1'b0;
      if (k == 0) begin
        check({name, " first_write"}, 64'({out_wr, out_rd, out_wr_addr, out_data}),
              64'({1'b1, 1'b0, 4'd0, 32'hA5C3_0F96}));
        check({name, " done_low_at_start"}, 64'(done), 64'(0));
      end
      if (out_wr) begin wr_cnt++; wr_data[out_wr_addr] = out_data; end
      if (out_rd) rd_cnt++;
      if (out_wr && out_rd) overlap++;
      if (busy) busy_cnt++;
      if (done) begin done_k = k; break; end
    end
    start = 1'b0;
    check({name, " done_edge"}, 64'(done_k), 64'(33));
    check({name, " busy_cycles"}, 64'(busy_cnt), 64'(33));
    check({name, " counts_wr_rd_overlap"}, 64'({wr_cnt[7:0], rd_cnt[7:0], overlap[7:0]}),
          64'({8'd16, 8'd16, 8'd0}));
    check({name, " err_count"}, 64'(err_count), 64'(exp_err));
    check({name, " fail_addr"}, 64'(fail_addr), 64'(exp_fail));
    check({name, " pass"}, 64'(pass), 64'(exp_err == 0));
    ec = err_count;
    repeat (3) @(negedge clk);
    check({name, " done_hold"}, 64'({done, busy, err_count}), 64'({1'b1, 1'b0, ec}));
  endtask

  initial begin
    clear_faults();
    repeat (2) @(negedge clk);
    check("reset_outputs", 64'({out_wr, out_rd, out_data, out_wr_addr, out_rd_addr,
                                busy, done, pass, fail_addr, err_count}), 64'(0));
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("idle_no_start", 64'({busy, done, out_wr, out_rd}), 64'(0));

    // Clean run from IDLE
    run("clean", 1'b0, 1'b0, 0, 0);
    check("clean wr_data0", 64'(wr_data[0]), 64'(32'hA5C3_0F96));
    check("clean wr_data9", 64'(wr_data[9]), 64'(32'hA5C3_0F9F));
    check("clean stored9", 64'(mem[9]), 64'(32'h0F9F_A5C3));

    // Single flipped bit at address 9 (restart from DONE)
    flt[9] = 32'h1;
    run("single_fault", 1'b0, 1'b0, 1, 9);
    clear_faults();

    // Plain RAM: every upper-half word is wrong
    swap_en = 1'b0;
    run("plain_ram", 1'b0, 1'b0, 8, 8);
    swap_en = 1'b1;

    // Stuck-at-zero read data: count saturates at DEPTH, no wrap
    stuck = 1'b1;
    run("stuck_zero", 1'b0, 1'b0, 16, 0);
    stuck = 1'b0;

    // Reset mid-READ
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    check("mid_read_active", 64'({busy, out_rd, out_wr}), 64'({1'b1, 1'b1, 1'b0}));
    rst = 1'b1;
    #1;
    check("mid_reset_outputs", 64'({out_wr, out_rd, out_data, out_wr_addr, out_rd_addr,
                                    busy, done, pass, fail_addr, err_count}), 64'(0));
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("post_reset_idle", 64'({busy, done, out_wr, out_rd, err_count}), 64'(0));
    end
    run("after_reset", 1'b0, 1'b0, 0, 0);

    // start held high for the whole run: no restart until DONE
    run("start_held", 1'b1, 1'b0, 0, 0);

    // Randomized fault maps, checked against the address-level model
    for (int it = 0; it < 4; it++) begin
      clear_faults();
      for (int a = 0; a < 16; a++)
        if ($urandom_range(0, 2) == 0) flt[a] = 32'(1) << $urandom_range(0, 31);
      repeat ($urandom_range(0, 5)) @(negedge clk);
      run($sformatf("random%0d", it), 1'($urandom_range(0, 1)), 1'b1, 0, 0);
    end
    clear_faults();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
